// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and 7-segment codes for the BCD display scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and stored active-high.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Maps an active-high pattern onto the pin polarity of the display.
    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
        logic [6:0] res;
        if (active_low) begin
            res = ~seg;
        end else begin
            res = seg;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7.sv
// Combinational BCD to active-high 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    // Digit lookup.
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes glitch-filtered BCD digits onto one 7-segment bus.
// Digits are latched once per scan frame so a frame never mixes old and new values.
module bcd_display_scanner
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [DW-1:0]         r_s1;
    logic [DW-1:0]         r_s2;
    logic [DW-1:0]         r_stable;
    logic [DW-1:0]         r_shadow;
    logic [NUM_DIGITS-1:0] r_lz_mask;
    logic                  r_active;
    logic                  r_frame;
    logic [IDX_W-1:0]      r_idx;
    logic [PRE_W-1:0]      r_pre;

    logic                  w_pre_last;
    logic                  w_idx_last;
    logic                  w_load;
    logic                  w_zero_run;
    logic [NUM_DIGITS-1:0] w_lz_mask;
    bcd_t                  w_digit;
    logic [6:0]            w_dec;
    logic [6:0]            w_seg_hi;
    logic [NUM_DIGITS-1:0] w_an_hi;

    assign w_pre_last = (r_pre == PRE_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_load     = !r_active || (w_pre_last && w_idx_last);

    // Blank digit i>0 when it and every more significant digit is zero.
    always_comb begin
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run   = w_zero_run & (r_stable[4*i +: 4] == 4'd0);
            w_lz_mask[i] = blank_lz_i & w_zero_run;
        end
    end

    // Input glitch filter: a value must be seen on two consecutive samples to pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
        end else begin
            r_s1 <= digits_i;
            r_s2 <= r_s1;
            if (r_s1 == r_s2) begin
                r_stable <= r_s2;
            end
        end
    end

    // Scan counters and once-per-frame shadow load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_lz_mask <= '0;
            r_active  <= 1'b0;
            r_frame   <= 1'b0;
            r_idx     <= '0;
            r_pre     <= '0;
        end else begin
            if (w_load) begin
                r_shadow  <= r_stable;
                r_lz_mask <= w_lz_mask;
                r_active  <= 1'b1;
                r_frame   <= 1'b1;
            end else begin
                r_frame   <= 1'b0;
            end
            if (r_active) begin
                if (w_pre_last) begin
                    r_pre <= '0;
                    r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    end

    assign w_digit = r_shadow[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

    // Output mux driven from registers only.
    always_comb begin
        w_an_hi  = '0;
        w_seg_hi = SEG_OFF;
        if (!r_active) begin
            w_an_hi  = '0;
            w_seg_hi = SEG_OFF;
        end else if (r_lz_mask[r_idx]) begin
            w_an_hi  = '0;
            w_seg_hi = SEG_OFF;
        end else begin
            w_an_hi[r_idx] = 1'b1;
            w_seg_hi       = w_dec;
        end
    end

    assign an_o    = ACTIVE_LOW ? ~w_an_hi : w_an_hi;
    assign seg_o   = seg_polarity(w_seg_hi, ACTIVE_LOW);
    assign frame_o = r_frame;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: stimulus queues per-frame expectations, a monitor checks each frame as it starts.
module tb_bcd_display_scanner;

    localparam logic [6:0] L0   = 7'b1000000;
    localparam logic [6:0] L1   = 7'b1111001;
    localparam logic [6:0] L2   = 7'b0100100;
    localparam logic [6:0] L3   = 7'b0110000;
    localparam logic [6:0] L4   = 7'b0011001;
    localparam logic [6:0] L5   = 7'b0010010;
    localparam logic [6:0] L7   = 7'b1111000;
    localparam logic [6:0] LD   = 7'b0111111;
    localparam logic [6:0] LOFF = 7'b1111111;

    typedef struct packed {
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_i;
    logic        blank_lz_i;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];

    bcd_display_scanner #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_i   (digits_i),
        .blank_lz_i (blank_lz_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (frame_o) seen = 1'b1;
        end
        chk("frame_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic push_exp(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] blank);
        exp_t       e;
        logic [6:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            if (blank[i]) begin
                e.an[i]  = 4'b1111;
                e.seg[i] = LOFF;
            end else begin
                e.an[i]  = 4'b1111 ^ (4'b0001 << i);
                e.seg[i] = s[i];
            end
        end
        q.push_back(e);
    endtask

    // Apply a setting at a frame start, then check the whole following frame.
    task automatic run_case(input logic [15:0] d, input logic b, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] blank);
        digits_i   = d;
        blank_lz_i = b;
        wait_frame();
        push_exp(s0, s1, s2, s3, blank);
        wait_frame();
    endtask

    // Monitor: when a frame starts and an expectation is pending, check all 16 cycles of it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_o && q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 16; k++) begin
                    if (k > 0) @(negedge clk);
                    chk($sformatf("an_slot%0d", k / 4), {28'd0, an_o}, {28'd0, e.an[k / 4]});
                    chk($sformatf("seg_slot%0d", k / 4), {25'd0, seg_o}, {25'd0, e.seg[k / 4]});
                    chk("frame_o", {31'd0, frame_o}, (k == 0) ? 32'd1 : 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        digits_i   = 16'h0123;
        blank_lz_i = 1'b0;
        #1;
        chk("rst_an", {28'd0, an_o}, 32'h0000000F);
        chk("rst_seg", {25'd0, seg_o}, 32'h0000007F);
        chk("rst_frame", {31'd0, frame_o}, 32'd0);
        #4 rst = 1'b0;

        // First frame after reset shows the cleared filter contents.
        wait_frame();
        push_exp(L0, L0, L0, L0, 4'b0000);
        wait_frame();
        push_exp(L3, L2, L1, L0, 4'b0000);
        wait_frame();

        run_case(16'h0007, 1'b1, L7, L0, L0, L0, 4'b1110);
        run_case(16'h0000, 1'b1, L0, L0, L0, L0, 4'b1110);
        run_case(16'h1000, 1'b1, L0, L0, L0, L1, 4'b0000);
        run_case(16'h00A5, 1'b0, L5, LD, L0, L0, 4'b0000);
        run_case(16'h0123, 1'b0, L3, L2, L1, L0, 4'b0000);

        // Short pulses early in a frame must not reach the display.
        push_exp(L3, L2, L1, L0, 4'b0000);
        push_exp(L3, L2, L1, L0, 4'b0000);
        repeat (2) begin @(posedge clk); #1; end
        digits_i = 16'hFFFF;
        @(posedge clk); #1;
        digits_i = 16'h0123;
        repeat (2) begin @(posedge clk); #1; end
        digits_i = 16'h0999;
        repeat (2) begin @(posedge clk); #1; end
        digits_i = 16'h0123;
        wait_frame();
        wait_frame();
        chk("shadow_after_glitch", {16'd0, dut.r_shadow}, 32'h00000123);

        // Mid-frame change must not tear the current frame.
        push_exp(L3, L2, L1, L0, 4'b0000);
        repeat (5) begin @(posedge clk); #1; end
        digits_i = 16'h4444;
        wait_frame();
        push_exp(L4, L4, L4, L4, 4'b0000);
        wait_frame();

        // Asynchronous reset while frame_o is high.
        chk("pre_rst_frame", {31'd0, frame_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_an", {28'd0, an_o}, 32'h0000000F);
        chk("mid_rst_seg", {25'd0, seg_o}, 32'h0000007F);
        chk("mid_rst_frame", {31'd0, frame_o}, 32'd0);
        #4 rst = 1'b0;
        wait_frame();
        push_exp(L0, L0, L0, L0, 4'b0000);
        wait_frame();
        push_exp(L4, L4, L4, L4, 4'b0000);
        wait_frame();

        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
